// File: rtl/bus_slave_port.sv
// Slave end of the serial system bus: deserialises address/write data, holds a small register file, serialises read data.
// Optional BUS_SLAVE_PARITY_EN adds an even-parity bit to write frames and to read data.
module bus_slave_port #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic bus_valid,
    input  logic bus_rw,
    input  logic bus_sdata,
    output logic slave_ready,
    output logic slave_valid,
    output logic slave_sdata,
    output logic slave_ack,
    output logic slave_err
);

    localparam int MAXW  = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CW    = $clog2(MAXW + 1);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        IDLE, ADDR, WDATA, WPARITY, WCOMMIT, RTURN, RDATA, RPARITY
    } state_t;

    state_t                  state_q;
    logic                    rw_q;
    logic [CW-1:0]           cnt_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rshift_q;
    logic                    ready_q;
    logic                    valid_q;
    logic                    sdata_q;
    logic                    ack_q;
    logic                    err_q;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic [DATA_WIDTH-1:0]   rd_word_d;
`ifdef BUS_SLAVE_PARITY_EN
    logic                    rpar_q;
`endif

    always_comb begin
        rd_word_d = mem_q[addr_q];
    end

    assign slave_ready = ready_q;
    assign slave_valid = valid_q;
    assign slave_sdata = sdata_q;
    assign slave_ack   = ack_q;
    assign slave_err   = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            rw_q     <= 1'b0;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rshift_q <= '0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            sdata_q  <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
`ifdef BUS_SLAVE_PARITY_EN
            rpar_q   <= 1'b0;
`endif
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus_valid) begin
                        rw_q    <= bus_rw;
                        addr_q  <= ADDR_WIDTH'(bus_sdata);
                        wdata_q <= '0;
                        ready_q <= 1'b0;
                        if (ADDR_WIDTH == 1) begin
                            cnt_q   <= '0;
                            state_q <= bus_rw ? WDATA : RTURN;
                        end else begin
                            cnt_q   <= CW'(1);
                            state_q <= ADDR;
                        end
                    end
                end
                ADDR: begin
                    if (!bus_valid) begin
                        cnt_q   <= '0;
                        err_q   <= 1'b1;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        addr_q <= (addr_q << 1) | ADDR_WIDTH'(bus_sdata);
                        if (cnt_q == CW'(ADDR_WIDTH - 1)) begin
                            cnt_q   <= '0;
                            state_q <= rw_q ? WDATA : RTURN;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                WDATA: begin
                    if (!bus_valid) begin
                        cnt_q   <= '0;
                        err_q   <= 1'b1;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        wdata_q <= (wdata_q << 1) | DATA_WIDTH'(bus_sdata);
                        if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                            cnt_q <= '0;
`ifdef BUS_SLAVE_PARITY_EN
                            state_q <= WPARITY;
`else
                            ack_q   <= 1'b1;
                            state_q <= WCOMMIT;
`endif
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                WPARITY: begin
                    // Even parity: address, data and parity bit must XOR to zero.
                    if (!bus_valid) begin
                        err_q   <= 1'b1;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end else if ((^addr_q ^ ^wdata_q ^ bus_sdata) == 1'b0) begin
                        ack_q   <= 1'b1;
                        state_q <= WCOMMIT;
                    end else begin
                        err_q   <= 1'b1;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                WCOMMIT: begin
                    mem_q[addr_q] <= wdata_q;
                    ready_q       <= 1'b1;
                    state_q       <= IDLE;
                end
                RTURN: begin
                    rshift_q <= rd_word_d << 1;
                    sdata_q  <= rd_word_d[DATA_WIDTH-1];
                    valid_q  <= 1'b1;
                    cnt_q    <= '0;
`ifdef BUS_SLAVE_PARITY_EN
                    rpar_q   <= ^rd_word_d;
`endif
                    state_q  <= RDATA;
                end
                RDATA: begin
                    if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                        cnt_q <= '0;
`ifdef BUS_SLAVE_PARITY_EN
                        sdata_q <= rpar_q;
                        state_q <= RPARITY;
`else
                        sdata_q <= 1'b0;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
`endif
                    end else begin
                        sdata_q  <= rshift_q[DATA_WIDTH-1];
                        rshift_q <= rshift_q << 1;
                        cnt_q    <= cnt_q + CW'(1);
                    end
                end
                RPARITY: begin
                    sdata_q <= 1'b0;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
